// File: rtl/psum_ofifo_if.sv
// rtl/psum_ofifo_if.sv - psum row bus between MAC array, output FIFO and row consumer
interface psum_ofifo_if #(
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int bw_psum = 2*bw+4
);
  logic [col*bw_psum-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*bw_psum-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   overflow;
  logic                   out_vld;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, overflow, out_vld
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, overflow, out_vld
  );
endinterface

// File: rtl/psum_ofifo.sv
// rtl/psum_ofifo.sv - per-lane psum FIFOs that fill skewed and pop as whole rows
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int bw_psum = 2*bw+4,
    parameter int depth   = 16
) (
    input logic        clk,
    input logic        reset,
    psum_ofifo_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  logic [bw_psum-1:0] mem [col][depth];
  logic [aw-1:0]      wptr [col];
  logic [aw-1:0]      rptr [col];
  logic [aw:0]        cnt  [col];

  logic [col*bw_psum-1:0] out_q;
  logic                   out_vld_q;
  logic                   overflow_q;
  logic [col-1:0]         lane_nonempty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         wr_ok;
  logic                   pop;

  always_comb begin
    lane_nonempty = '0;
    lane_full     = '0;
    for (int i = 0; i < col; i++) begin
      lane_nonempty[i] = (cnt[i] != '0);
      lane_full[i]     = (cnt[i] == full_cnt);
    end
  end

  // A full lane still takes a write when the row pop frees its head slot.
  assign pop   = bus.rd & (&lane_nonempty);
  assign wr_ok = bus.wr & (~lane_full | {col{pop}});

  assign bus.o_valid  = &lane_nonempty;
  assign bus.o_full   = |lane_full;
  assign bus.o_ready  = ~(|lane_full);
  assign bus.out      = out_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.overflow = overflow_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_ok[i]) mem[i][wptr[i]] <= bus.in[i*bw_psum +: bw_psum];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_vld_q <= pop;
      if (|(bus.wr & ~wr_ok)) overflow_q <= 1'b1;
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i]) wptr[i] <= wptr[i] + aw'(1);
        if (pop) begin
          rptr[i] <= rptr[i] + aw'(1);
          out_q[i*bw_psum +: bw_psum] <= mem[i][rptr[i]];
        end
        if (wr_ok[i] && !pop)      cnt[i] <= cnt[i] + (aw+1)'(1);
        else if (pop && !wr_ok[i]) cnt[i] <= cnt[i] - (aw+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_psum_ofifo.sv
// tb/tb_psum_ofifo.sv - self-checking bench for psum_ofifo against a queue-based lane model
module tb_psum_ofifo;
  localparam int COL   = 8;
  localparam int BW    = 4;
  localparam int BWP   = 2*BW+4;
  localparam int DEPTH = 16;
  localparam int W     = COL*BWP;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  psum_ofifo_if #(.col(COL), .bw(BW), .bw_psum(BWP)) bus ();
  psum_ofifo #(.col(COL), .bw(BW), .bw_psum(BWP), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BWP-1:0] q [COL][$];
  logic [W-1:0]   exp_out;
  logic           exp_vld;
  logic           exp_ovf;

  function automatic bit model_valid();
    for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BWP +: BWP] = BWP'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < COL; i++) q[i].delete();
    exp_out = '0;
    exp_vld = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Drive one cycle, advance the model, and return #1 after the edge.
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    bit p;
    p = r && model_valid();
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    exp_vld = p;
    if (p) for (int i = 0; i < COL; i++) exp_out[i*BWP +: BWP] = q[i].pop_front();
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(d[i*BWP +: BWP]);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.wr = '0;
    bus.rd = 1'b0;
    reset  = 1'b0;
    #3;
    reset  = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    #7;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_full !== 1'b0) begin failures++; $display("FAIL reset_o_full got=%b exp=0", bus.o_full); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", bus.o_ready); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", bus.out_vld); end
    #5;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_skew();
    logic [W-1:0]   d;
    logic [W-1:0]   row;
    logic [COL-1:0] w;
    apply_reset();
    row = '0;
    for (int i = 0; i < COL; i++) begin
      d = '0;
      w = '0;
      w[i] = 1'b1;
      d[i*BWP +: BWP]   = BWP'(16*i+1);
      row[i*BWP +: BWP] = BWP'(16*i+1);
      step(w, d, 1'b0);
      checks++; if (bus.o_valid !== (i == COL-1)) begin failures++; $display("FAIL skew_o_valid lane=%0d got=%b exp=%b", i, bus.o_valid, (i == COL-1)); end
    end
    step('0, '0, 1'b1);
    checks++; if (bus.out !== row) begin failures++; $display("FAIL skew_out got=%h exp=%h", bus.out, row); end
    checks++; if (bus.out_vld !== 1'b1) begin failures++; $display("FAIL skew_out_vld got=%b exp=1", bus.out_vld); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL skew_o_valid_after got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] d;
    apply_reset();
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < COL; i++) d[i*BWP +: BWP] = BWP'(k*COL+i);
      step('1, d, 1'b0);
    end
    checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL fill_o_full got=%b exp=1", bus.o_full); end
    checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL fill_o_ready got=%b exp=0", bus.o_ready); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fill_no_overflow got=%b exp=0", bus.overflow); end
    step('1, rand_row(), 1'b0);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", bus.overflow); end
    checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL overflow_o_full got=%b exp=1", bus.o_full); end
    for (int k = 0; k < DEPTH; k++) begin
      step('0, '0, 1'b1);
      checks++; if (bus.out[BWP-1:0] !== BWP'(k*COL)) begin failures++; $display("FAIL drain_lane0 k=%0d got=%0d exp=%0d", k, bus.out[BWP-1:0], k*COL); end
      checks++; if (bus.out !== exp_out) begin failures++; $display("FAIL drain_row k=%0d got=%h exp=%h", k, bus.out, exp_out); end
    end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.o_valid); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int k = 0; k < DEPTH; k++) step('1, rand_row(), 1'b0);
    step('1, rand_row(), 1'b1);
    checks++; if (bus.out !== exp_out) begin failures++; $display("FAIL simul_out got=%h exp=%h", bus.out, exp_out); end
    checks++; if (bus.out_vld !== 1'b1) begin failures++; $display("FAIL simul_out_vld got=%b exp=1", bus.out_vld); end
    checks++; if (bus.o_full !== 1'b1) begin failures++; $display("FAIL simul_o_full got=%b exp=1", bus.o_full); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL simul_overflow got=%b exp=0", bus.overflow); end
    for (int k = 0; k < DEPTH; k++) begin
      step('0, '0, 1'b1);
      checks++; if (bus.out !== exp_out) begin failures++; $display("FAIL simul_drain k=%0d got=%h exp=%h", k, bus.out, exp_out); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] rows [$];
    logic [W-1:0] d;
    int pops;
    apply_reset();
    pops = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k < 40) begin
        d = rand_row();
        rows.push_back(d);
        step('1, d, 1'b1);
      end else begin
        step('0, '0, 1'b1);
      end
      if (bus.out_vld === 1'b1) begin
        checks++; if (pops >= 40 || bus.out !== rows[pops]) begin failures++; $display("FAIL wrap_row n=%0d got=%h", pops, bus.out); end
        pops++;
      end
    end
    checks++; if (pops !== 40) begin failures++; $display("FAIL wrap_count got=%0d exp=40", pops); end
  endtask

  task automatic test_empty_read();
    logic [W-1:0] d;
    logic [W-1:0] d2;
    apply_reset();
    d = rand_row();
    step('1, d, 1'b0);
    step('0, '0, 1'b1);
    checks++; if (bus.out !== d) begin failures++; $display("FAIL empty_prime got=%h exp=%h", bus.out, d); end
    step('0, '0, 1'b1);
    checks++; if (bus.out !== d) begin failures++; $display("FAIL empty_out_hold got=%h exp=%h", bus.out, d); end
    checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL empty_out_vld got=%b exp=0", bus.out_vld); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL empty_o_valid got=%b exp=0", bus.o_valid); end
    d2 = rand_row();
    step('1, d2, 1'b0);
    step('0, '0, 1'b1);
    checks++; if (bus.out !== d2) begin failures++; $display("FAIL empty_ptr got=%h exp=%h", bus.out, d2); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    apply_reset();
    for (int k = 0; k < 6; k++) step('1, rand_row(), 1'b0);
    step('0, '0, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL midrst_o_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.out !== '0) begin failures++; $display("FAIL midrst_out got=%h exp=0", bus.out); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", bus.overflow); end
    #1;
    reset = 1'b1;
    model_reset();
    d = rand_row();
    step('1, d, 1'b0);
    step('0, '0, 1'b1);
    checks++; if (bus.out !== d) begin failures++; $display("FAIL midrst_new_row got=%h exp=%h", bus.out, d); end
    step('0, '0, 1'b1);
    checks++; if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b exp=0", bus.out_vld); end
  endtask

  task automatic test_random();
    logic [COL-1:0] w;
    logic           r;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      w = COL'($urandom);
      r = ($urandom_range(0, 99) < ((n < 200) ? 30 : 70));
      step(w, rand_row(), r);
      checks++; if (bus.out !== exp_out) begin failures++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, bus.out, exp_out); end
      checks++; if (bus.out_vld !== exp_vld) begin failures++; $display("FAIL rand_out_vld n=%0d got=%b exp=%b", n, bus.out_vld, exp_vld); end
      checks++; if (bus.overflow !== exp_ovf) begin failures++; $display("FAIL rand_overflow n=%0d got=%b exp=%b", n, bus.overflow, exp_ovf); end
      checks++; if (bus.o_valid !== model_valid()) begin failures++; $display("FAIL rand_o_valid n=%0d got=%b exp=%b", n, bus.o_valid, model_valid()); end
      checks++; if (bus.o_full !== model_full()) begin failures++; $display("FAIL rand_o_full n=%0d got=%b exp=%b", n, bus.o_full, model_full()); end
      checks++; if (bus.o_ready !== !model_full()) begin failures++; $display("FAIL rand_o_ready n=%0d got=%b exp=%b", n, bus.o_ready, !model_full()); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_skew();
    test_fill_overflow();
    test_simultaneous();
    test_wrap();
    test_empty_read();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 SHALL have parameter col, default 8: number of columns/lanes.
REQ-002 SHALL have parameter bw, default 4: operand width.
REQ-003 SHALL have parameter bw_psum, default 2*bw+4: partial-sum width per lane.
REQ-004 SHALL have parameter depth, default 16: entries per lane; must be a power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port in, input, col*bw_psum bits: lane i psum at bits [bw_psum*(i+1)-1 : bw_psum*i], driven by the MAC array out bus.
REQ-008 SHALL have port wr, input, col bits: per-lane write strobe, driven by the MAC array fifo_wr.
REQ-009 SHALL have port rd, input, 1 bit: row pop request.
REQ-010 SHALL have port out, output, col*bw_psum bits: registered popped row, with the same lane packing as in.
REQ-011 SHALL have port o_valid, output, 1 bit: every lane is non-empty, so a full row is poppable.
REQ-012 SHALL have port o_full, output, 1 bit: at least one lane is full.
REQ-013 SHALL have port o_ready, output, 1 bit: no lane is full (equal to ~o_full).
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag for a dropped write.
REQ-015 SHALL have port out_vld, output, 1 bit: out was updated by the previous cycle's pop.

Function
REQ-016 SHALL keep col independent circular lanes, each with a depth x bw_psum storage array, a write pointer and a read pointer of log2(depth) bits, and a count of log2(depth)+1 bits.
REQ-017 SHALL accept a write to lane i when wr[i]=1 and either (count_i < depth) or a pop is accepted in the same cycle.
- Accepted write: store in[lane i] at wptr_i, then wptr_i increments modulo depth.
REQ-018 SHALL drop a write with wr[i]=1, count_i=depth and no accepted pop, leaving lane i unchanged and setting overflow=1 from the next cycle until reset.
REQ-019 SHALL accept a pop when rd=1 and o_valid=1.
- Pops all lanes together; every rptr_i increments modulo depth.
REQ-020 SHALL ignore rd when o_valid=0: no pointer change, out holds, out_vld=0 next cycle.
REQ-021 SHALL load out with the head entry of every lane, and set out_vld=1, on the cycle after an accepted pop (latency 1); otherwise out holds and out_vld=0.
REQ-022 SHALL update count_i per cycle as: +1 on write only, -1 on pop only, unchanged on both or neither.
REQ-023 SHALL derive o_valid, o_full and o_ready combinationally from the registered counts only.
- A write in cycle N becomes visible to o_valid in cycle N+1; no bypass from write to read.
REQ-024 SHALL allow lanes to fill skewed: lane i+1 may lag lane i by any number of cycles; a row pops only once all lanes hold it.
REQ-025 SHALL wrap both pointers from depth-1 to 0 without a bubble and without data loss.
REQ-026 SHALL keep the storage arrays unreset; only pointers, counts, out, out_vld and overflow are reset.

Reset
REQ-027 SHALL, while reset=0 (asynchronously), clear all pointers and counts to 0, out to 0, out_vld to 0 and overflow to 0.
- Resulting outputs: o_valid=0, o_full=0, o_ready=1.
REQ-028 SHALL, if reset is asserted mid-operation, discard all queued entries.
- After release, the first accepted write to each lane lands at address 0, and no stale row is popped.
REQ-029 SHALL respond to wr/rd starting from the first rising clk edge after reset returns to 1.

Verification
REQ-030 SHALL pass the skew test: col=8, lane i written with value 16*i+1 at cycle i, i=0..7.
- o_valid rises only in cycle 8.
- rd=1 in cycle 8 gives out lanes = {113,97,...,17,1} and out_vld=1 in cycle 9, with o_valid=0.
REQ-031 SHALL pass the fill/overflow test: 16 writes to all lanes -> o_full=1, o_ready=0.
- A 17th write with rd=0 -> overflow=1 and counts stay 16.
- 16 pops then return entries 0..15 in order.
REQ-032 SHALL pass the simultaneous test: all lanes full, wr=all ones and rd=1 together.
- Pop is accepted and the write is accepted; counts stay 16, o_full stays 1, overflow stays 0.
REQ-033 SHALL pass the wrap test: 40 rows streamed with rd held high and writes at 1 row/cycle.
- Output order matches input order across two pointer wraps, with no lost or duplicated row.
REQ-034 SHALL pass the empty-read test: rd=1 with all counts 0 -> out unchanged, out_vld=0, pointers unchanged.
REQ-035 SHALL pass the reset test: reset pulsed low between clocks with 5 rows queued.
- Immediately o_valid=0, out=0, overflow=0.
- One new row written after release pops as that row, not a stale one.
